// File: rtl/tl_ul_scratchpad_responder.sv
`timescale 1ns/1ps
// tl_ul_scratchpad_responder
// Single-beat TileLink-UL manager that fronts a DEPTH x 64-bit flop scratchpad.
// Every accepted A request is decoded and fully executed at its accept edge.
// A one-entry response register drives channel D one cycle later, and it can
// reload in the same cycle it drains, so throughput is one request per cycle.
//
// Handshake: a beat transfers on a channel only on a rising edge where
// valid && ready. Once raised, d_valid stays high and d_bits stay stable until
// d_ready is seen. a_ready depends only on the response register and d_ready,
// never on a_valid.
module tl_ul_scratchpad_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_bits_opcode,
  input  logic [2:0]  a_bits_param,
  input  logic [3:0]  a_bits_size,
  input  logic [1:0]  a_bits_source,
  input  logic [31:0] a_bits_address,
  input  logic [7:0]  a_bits_mask,
  input  logic [63:0] a_bits_data,
  input  logic        a_bits_corrupt,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_bits_opcode,
  output logic [1:0]  d_bits_param,
  output logic [3:0]  d_bits_size,
  output logic [1:0]  d_bits_source,
  output logic [2:0]  d_bits_sink,
  output logic        d_bits_denied,
  output logic [63:0] d_bits_data,
  output logic        d_bits_corrupt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = IDX_W + 3;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] D_ACK         = 3'd0;
  localparam logic [2:0] D_ACK_DATA    = 3'd1;

  logic [63:0]      mem [DEPTH];

  logic             rsp_valid;
  logic [2:0]       rsp_opcode;
  logic [3:0]       rsp_size;
  logic [1:0]       rsp_source;
  logic             rsp_denied;
  logic             rsp_corrupt;
  logic [63:0]      rsp_data;

  logic             a_fire;
  logic             hit;
  logic             aligned;
  logic             is_get;
  logic             is_put;
  logic             ok;
  logic [IDX_W-1:0] idx;
  logic             unused_param;

  assign a_ready      = !rsp_valid || d_ready;
  assign a_fire       = a_valid && a_ready;
  assign unused_param = ^a_bits_param;

  // Request decode: address window, natural alignment, opcode legality.
  always_comb begin
    hit     = 1'b0;
    aligned = 1'b0;
    is_get  = 1'b0;
    is_put  = 1'b0;
    ok      = 1'b0;
    idx     = a_bits_address[3 +: IDX_W];
    // BASE_ADDR is aligned to the window size, so the window is a tag match.
    hit     = (a_bits_address[31:OFF_W] == BASE_ADDR[31:OFF_W]);
    case (a_bits_size)
      4'd0:    aligned = 1'b1;
      4'd1:    aligned = (a_bits_address[0] == 1'b0);
      4'd2:    aligned = (a_bits_address[1:0] == 2'b00);
      4'd3:    aligned = (a_bits_address[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
    is_get = (a_bits_opcode == A_GET);
    is_put = (a_bits_opcode == A_PUT_FULL) || (a_bits_opcode == A_PUT_PARTIAL);
    ok     = hit && aligned && (is_get || is_put) && !(is_put && a_bits_corrupt);
  end

  // Scratchpad: byte-lane writes from accepted, legal Puts; cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (a_fire && is_put && ok) begin
      for (int b = 0; b < 8; b++) begin
        if (a_bits_mask[b]) begin
          mem[idx][8*b +: 8] <= a_bits_data[8*b +: 8];
        end
      end
    end
  end

  // Response register: load on accept, empty on drain without a new accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_opcode  <= '0;
      rsp_size    <= '0;
      rsp_source  <= '0;
      rsp_denied  <= 1'b0;
      rsp_corrupt <= 1'b0;
      rsp_data    <= '0;
    end else if (a_fire) begin
      rsp_valid   <= 1'b1;
      rsp_opcode  <= is_get ? D_ACK_DATA : D_ACK;
      rsp_size    <= a_bits_size;
      rsp_source  <= a_bits_source;
      rsp_denied  <= !ok;
      rsp_corrupt <= is_get && !ok;
      // Reads see the pre-edge contents; a Get never writes anyway.
      rsp_data    <= (is_get && ok) ? mem[idx] : '0;
    end else if (rsp_valid && d_ready) begin
      rsp_valid   <= 1'b0;
      rsp_opcode  <= '0;
      rsp_size    <= '0;
      rsp_source  <= '0;
      rsp_denied  <= 1'b0;
      rsp_corrupt <= 1'b0;
      rsp_data    <= '0;
    end
  end

  assign d_valid        = rsp_valid;
  assign d_bits_opcode  = rsp_opcode;
  assign d_bits_param   = '0;
  assign d_bits_size    = rsp_size;
  assign d_bits_source  = rsp_source;
  assign d_bits_sink    = '0;
  assign d_bits_denied  = rsp_denied;
  assign d_bits_data    = rsp_data;
  assign d_bits_corrupt = rsp_corrupt;

endmodule

// File: tb/tb_tl_ul_scratchpad_responder.sv
`timescale 1ns/1ps
// Bench for tl_ul_scratchpad_responder: a transaction-level model predicts the
// D channel every cycle; directed sequences pin literal responses.
module tb_tl_ul_scratchpad_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 64;
  localparam int          RSP_W = 75;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_bits_opcode;
  logic [2:0]  a_bits_param;
  logic [3:0]  a_bits_size;
  logic [1:0]  a_bits_source;
  logic [31:0] a_bits_address;
  logic [7:0]  a_bits_mask;
  logic [63:0] a_bits_data;
  logic        a_bits_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_param;
  logic [3:0]  d_bits_size;
  logic [1:0]  d_bits_source;
  logic [2:0]  d_bits_sink;
  logic        d_bits_denied;
  logic [63:0] d_bits_data;
  logic        d_bits_corrupt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [2:0]  opc;
    logic [1:0]  src;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
    int          cyc;
  } dlog_t;

  dlog_t            d_log[$];
  logic [RSP_W-1:0] exp_q[$];
  logic [63:0]      model_mem [DEPTH];

  tl_ul_scratchpad_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param),
    .a_bits_size(a_bits_size), .a_bits_source(a_bits_source),
    .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask),
    .a_bits_data(a_bits_data), .a_bits_corrupt(a_bits_corrupt),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
    .d_bits_size(d_bits_size), .d_bits_source(d_bits_source),
    .d_bits_sink(d_bits_sink), .d_bits_denied(d_bits_denied),
    .d_bits_data(d_bits_data), .d_bits_corrupt(d_bits_corrupt)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: what the response to one request must be, and its memory effect.
  function automatic logic [RSP_W-1:0] model_access(
    input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
    input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
    input logic corrupt);
    longint unsigned a;
    longint unsigned lo;
    longint unsigned hi;
    bit          in_range;
    bit          al;
    bit          get;
    bit          put;
    bit          good;
    int          word;
    logic [63:0] rdata;
    a        = longint'(addr);
    lo       = longint'(BASE);
    hi       = lo + DEPTH * 8;
    in_range = (a >= lo) && (a < hi);
    al       = (sz <= 3) && ((a % (64'd1 << sz)) == 0);
    get      = (op == 3'd4);
    put      = (op == 3'd0) || (op == 3'd1);
    good     = in_range && al && (get || put) && !(put && corrupt);
    word     = in_range ? int'((a - lo) / 8) : 0;
    rdata    = (get && good) ? model_mem[word] : 64'd0;
    if (put && good) begin
      for (int b = 0; b < 8; b++) begin
        if (mask[b]) model_mem[word][8*b +: 8] = data[8*b +: 8];
      end
    end
    return {(get ? 3'd1 : 3'd0), sz, src, !good, get && !good, rdata};
  endfunction

  // Scoreboard compare: every cycle, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_d_valid", 80'(d_valid), 80'd0);
      check("rst_a_ready", 80'(a_ready), 80'd1);
      check("rst_d_bits", 80'({d_bits_opcode, d_bits_size, d_bits_source, d_bits_denied,
                               d_bits_corrupt, d_bits_data}), 80'd0);
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
    end else begin
      check("d_valid", 80'(d_valid), 80'(exp_q.size() != 0));
      check("a_ready", 80'(a_ready), 80'((exp_q.size() == 0) || d_ready));
      if (exp_q.size() != 0) begin
        check("d_bits", 80'({d_bits_opcode, d_bits_size, d_bits_source, d_bits_denied,
                             d_bits_corrupt, d_bits_data}), 80'(exp_q[0]));
        check("d_param_sink", 80'({d_bits_param, d_bits_sink}), 80'd0);
      end
      if (a_valid && ((exp_q.size() == 0) || d_ready)) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(model_access(a_bits_opcode, a_bits_size, a_bits_source,
                                     a_bits_address, a_bits_mask, a_bits_data,
                                     a_bits_corrupt));
      end else if (d_ready && (exp_q.size() != 0)) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // D-channel monitor: log every completed response for literal checks.
  always @(negedge clock) begin
    dlog_t e;
    if (reset && d_valid && d_ready) begin
      e.opc     = d_bits_opcode;
      e.src     = d_bits_source;
      e.denied  = d_bits_denied;
      e.corrupt = d_bits_corrupt;
      e.data    = d_bits_data;
      e.cyc     = cyc;
      d_log.push_back(e);
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                      input logic [31:0] addr, input logic [7:0] mask,
                      input logic [63:0] data, input logic corrupt);
    int waited;
    waited         = 0;
    a_valid        = 1'b1;
    a_bits_opcode  = op;
    a_bits_param   = 3'($urandom_range(0, 7));
    a_bits_size    = sz;
    a_bits_source  = src;
    a_bits_address = addr;
    a_bits_mask    = mask;
    a_bits_data    = data;
    a_bits_corrupt = corrupt;
    @(negedge clock);
    while (!a_ready && waited < 50) begin
      waited++;
      @(negedge clock);
    end
    if (!a_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: a_ready stayed 0, expected 1 within 50 cycles");
    end
    @(posedge clock);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic check_log(input string name, input int i, input logic [2:0] opc,
                           input logic [1:0] src, input logic den, input logic cor,
                           input logic [63:0] data);
    if (i >= d_log.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: response %0d missing, got %0d responses", name, i, d_log.size());
    end else begin
      check(name, 80'({d_log[i].opc, d_log[i].src, d_log[i].denied, d_log[i].corrupt,
                       d_log[i].data}),
            80'({opc, src, den, cor, data}));
    end
  endtask

  initial begin
    int rel_cyc;
    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    a_bits_opcode = '0; a_bits_param = '0; a_bits_size = '0; a_bits_source = '0;
    a_bits_address = '0; a_bits_mask = '0; a_bits_data = '0; a_bits_corrupt = 1'b0;
    @(posedge clock); #1;
    check("init_d_valid", 80'(d_valid), 80'd0);
    check("init_a_ready", 80'(a_ready), 80'd1);
    idle(2);
    reset = 1'b1;

    // full write and read-back
    d_log.delete();
    send(3'd0, 4'd3, 2'd2, BASE + 32'd8, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    send(3'd4, 4'd3, 2'd1, BASE + 32'd8, 8'hFF, 64'd0, 1'b0);
    idle(2);
    check_log("full_put", 0, 3'd0, 2'd2, 1'b0, 1'b0, 64'd0);
    check_log("full_get", 1, 3'd1, 2'd1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);
    check("full_b2b", 80'(d_log[1].cyc - d_log[0].cyc), 80'd1);

    // partial write, mask ignored on the Get
    d_log.delete();
    send(3'd1, 4'd3, 2'd0, BASE + 32'd8, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(3'd4, 4'd3, 2'd3, BASE + 32'd8, 8'h00, 64'd0, 1'b0);
    idle(2);
    check_log("part_put", 0, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0);
    check_log("part_get", 1, 3'd1, 2'd3, 1'b0, 1'b0, 64'h0123_4567_FFFF_FFFF);

    // denials
    d_log.delete();
    send(3'd4, 4'd3, 2'd0, BASE + DEPTH * 8, 8'hFF, 64'd0, 1'b0);
    send(3'd0, 4'd2, 2'd1, BASE + 32'd10, 8'hFF, 64'd0, 1'b0);
    send(3'd2, 4'd3, 2'd2, BASE + 32'd8, 8'hFF, 64'd0, 1'b0);
    send(3'd0, 4'd3, 2'd3, BASE + 32'd8, 8'hFF, 64'd0, 1'b1);
    send(3'd4, 4'd3, 2'd0, BASE - 32'd8, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 4'd1, 2'd1, BASE + 32'd9, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 4'd4, 2'd2, BASE + 32'd16, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 4'd3, 2'd3, BASE + 32'd8, 8'hFF, 64'd0, 1'b0);
    idle(2);
    check_log("deny_get_oob", 0, 3'd1, 2'd0, 1'b1, 1'b1, 64'd0);
    check_log("deny_put_misal", 1, 3'd0, 2'd1, 1'b1, 1'b0, 64'd0);
    check_log("deny_opcode2", 2, 3'd0, 2'd2, 1'b1, 1'b0, 64'd0);
    check_log("deny_put_corrupt", 3, 3'd0, 2'd3, 1'b1, 1'b0, 64'd0);
    check_log("deny_get_below", 4, 3'd1, 2'd0, 1'b1, 1'b1, 64'd0);
    check_log("deny_get_misal", 5, 3'd1, 2'd1, 1'b1, 1'b1, 64'd0);
    check_log("deny_get_size4", 6, 3'd1, 2'd2, 1'b1, 1'b1, 64'd0);
    check_log("deny_mem_kept", 7, 3'd1, 2'd3, 1'b0, 1'b0, 64'h0123_4567_FFFF_FFFF);

    // top word and single-byte put
    d_log.delete();
    send(3'd0, 4'd3, 2'd1, BASE + 32'd504, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    send(3'd0, 4'd0, 2'd2, BASE + 32'h1B, 8'h08, 64'h0000_0000_AA00_0000, 1'b0);
    send(3'd4, 4'd3, 2'd0, BASE + 32'd504, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 4'd3, 2'd1, BASE + 32'h18, 8'hFF, 64'd0, 1'b0);
    idle(2);
    check_log("top_put", 0, 3'd0, 2'd1, 1'b0, 1'b0, 64'd0);
    check_log("byte_put", 1, 3'd0, 2'd2, 1'b0, 1'b0, 64'd0);
    check_log("top_get", 2, 3'd1, 2'd0, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
    check_log("byte_get", 3, 3'd1, 2'd1, 1'b0, 1'b0, 64'h0000_0000_AA00_0000);

    // backpressure
    d_log.delete();
    send(3'd4, 4'd3, 2'd3, BASE + 32'd8, 8'hFF, 64'd0, 1'b0);
    d_ready        = 1'b0;
    a_valid        = 1'b1;
    a_bits_opcode  = 3'd4;
    a_bits_size    = 4'd3;
    a_bits_source  = 2'd0;
    a_bits_address = BASE + 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_a_ready", 80'(a_ready), 80'd0);
      check("bp_d_hold", 80'({d_valid, d_bits_opcode, d_bits_source, d_bits_data}),
            80'({1'b1, 3'd1, 2'd3, 64'h0123_4567_FFFF_FFFF}));
    end
    @(posedge clock); #1;
    d_ready = 1'b1;
    @(negedge clock);
    check("bp_release_fire", 80'(a_ready && a_valid), 80'd1);
    @(posedge clock); #1;
    a_valid = 1'b0;
    idle(2);
    check_log("bp_first", 0, 3'd1, 2'd3, 1'b0, 1'b0, 64'h0123_4567_FFFF_FFFF);
    check_log("bp_second", 1, 3'd1, 2'd0, 1'b0, 1'b0, 64'd0);

    // streaming
    d_log.delete();
    for (int i = 0; i < 16; i++) begin
      send(3'd4, 4'd3, 2'(i % 4), BASE + 32'(8 * i), 8'hFF, 64'd0, 1'b0);
    end
    idle(3);
    check("stream_count", 80'(d_log.size()), 80'd16);
    for (int i = 0; i < d_log.size(); i++) begin
      check("stream_src", 80'(d_log[i].src), 80'(i % 4));
      check("stream_gap", 80'(d_log[i].cyc - d_log[0].cyc), 80'(i));
    end
    check_log("stream_w1", 1, 3'd1, 2'd1, 1'b0, 1'b0, 64'h0123_4567_FFFF_FFFF);
    check_log("stream_w3", 3, 3'd1, 2'd3, 1'b0, 1'b0, 64'h0000_0000_AA00_0000);

    // reset mid-transfer
    send(3'd4, 4'd3, 2'd1, BASE + 32'd8, 8'hFF, 64'd0, 1'b0);
    d_ready = 1'b0;
    @(negedge clock);
    check("rst_pre_valid", 80'(d_valid), 80'd1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("rst_mid_d_valid", 80'(d_valid), 80'd0);
    check("rst_mid_a_ready", 80'(a_ready), 80'd1);
    check("rst_mid_d_bits", 80'({d_bits_opcode, d_bits_source, d_bits_data}), 80'd0);
    d_ready = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b1;
    rel_cyc = cyc;
    d_log.delete();
    send(3'd4, 4'd3, 2'd0, BASE, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 4'd3, 2'd1, BASE + 32'd8, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 4'd3, 2'd2, BASE + 32'h18, 8'hFF, 64'd0, 1'b0);
    idle(2);
    check("rst_first_accept", 80'(d_log.size() > 0 ? d_log[0].cyc - rel_cyc : -1), 80'd1);
    check_log("rst_get_base", 0, 3'd1, 2'd0, 1'b0, 1'b0, 64'd0);
    check_log("rst_get_w1", 1, 3'd1, 2'd1, 1'b0, 1'b0, 64'd0);
    check_log("rst_get_w3", 2, 3'd1, 2'd2, 1'b0, 1'b0, 64'd0);
    check("rst_no_replay", 80'(d_log.size()), 80'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_ul_scratchpad_responder.md
# tl_ul_scratchpad_responder

Single-beat TileLink-UL responder (manager side) exposing a small register-backed scratchpad on a 32-bit address / 64-bit data link. It is the D-channel-driving counterpart to the bridge emulator's master punch-through port. It accepts Get, PutFullData and PutPartialData on channel A and returns AccessAckData or AccessAck on channel D. A one-entry output register provides one-cycle latency and full back-to-back throughput. Bringup tests and emulator builds use it to give a punch-through master a live target.

## Interface
- BASE_ADDR, 32'h1000_0000: byte address of word 0; must be aligned to DEPTH*8.
- DEPTH, 64: number of 64-bit words; power of two, 2..256.
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_valid  input  1  A request valid.
- a_ready  output  1  A request accepted when a_valid && a_ready.
- a_bits_opcode  input  3  0 PutFullData, 1 PutPartialData, 4 Get; all others unsupported.
- a_bits_param  input  3  ignored.
- a_bits_size  input  4  log2 bytes; 0..3 legal.
- a_bits_source  input  2  echoed on D.
- a_bits_address  input  32  byte address.
- a_bits_mask  input  8  byte lanes.
- a_bits_data  input  64  write data.
- a_bits_corrupt  input  1  if 1 on a Put, write suppressed, response denied.
- d_valid  output  1  response valid.
- d_ready  input  1  response accepted.
- d_bits_opcode  output  3  1 AccessAckData (Get), 0 AccessAck (all others).
- d_bits_param  output  2  always 0.
- d_bits_size  output  4  echo of a_bits_size.
- d_bits_source  output  2  echo of a_bits_source.
- d_bits_sink  output  3  always 0.
- d_bits_denied  output  1  request rejected.
- d_bits_data  output  64  read data; 0 when not AccessAckData or denied.
- d_bits_corrupt  output  1  equals d_bits_denied on AccessAckData, else 0.

## Operation
- Accept: a_fire = a_valid && a_ready. Request is fully processed at a_fire; no internal request queue.
- Decode, all evaluated at a_fire:
  - hit = address in [BASE_ADDR, BASE_ADDR + DEPTH*8).
  - aligned = address low a_bits_size bits are zero, and size ≤ 3.
  - index = address[3 +: log2(DEPTH)].
  - ok = hit && aligned && opcode ∈ {0,1,4} && !(Put && a_bits_corrupt).
- Get, ok: response is AccessAckData carrying mem[index] (full 64-bit word, pre-write value). Mask is ignored.
- Get, !ok: response is AccessAckData with denied=1, corrupt=1, data=0.
- Put (0 or 1), ok: for each lane i with mask[i]=1, write byte i of mem[index] at the a_fire edge. Response is AccessAck, denied=0. Full and partial puts are treated identically.
- Put !ok, or unsupported opcode: no write. Response is AccessAck with denied=1.
- Memory: DEPTH x 64 flops, cleared to 0 by reset. Only Puts with ok=1 modify it.
- Response register: loaded at every a_fire; d_valid is set at that edge. It is cleared when d_ready && d_valid and there is no a_fire in the same cycle.

## Timing
- a_ready = !d_valid || d_ready. This is combinational from d_ready and has no dependency on a_valid.
- Latency: the response appears on D exactly 1 cycle after a_fire.
- Throughput: 1 request per cycle while d_ready=1 is held.
- Backpressure: while d_valid && !d_ready, all d_bits stay stable and a_ready=0.
- Same-cycle D drain and new A: the register reloads at that edge and d_valid stays 1.
- Write then read of the same index on consecutive cycles: the Get returns the new value. The write has committed at the earlier edge.
- Reset assertion, any time including mid-handshake:
  - d_valid=0 immediately.
  - All d_bits=0.
  - Memory cleared.
  - a_ready=1 (follows from d_valid=0).
- A pending response is dropped on reset and not replayed.
- Reset deassertion: the first accept is possible in the first cycle after deassertion.

## Test plan
- **Reset values**: assert reset mid-transfer with d_valid=1 and d_ready=0 -> d_valid=0, a_ready=1 within the same cycle; a Get of BASE_ADDR after release returns data 0.
- **Full write and read-back**: PutFullData, size 3, addr BASE_ADDR+8, mask FF, data 64'h0123_4567_89AB_CDEF, source 2 -> AccessAck, source 2, denied 0. Next-cycle Get of same addr, source 1 -> AccessAckData, data 64'h0123_4567_89AB_CDEF, corrupt 0.
- **Partial write**: PutPartialData to BASE_ADDR+8, size 3, mask 8'h0F, data all-ones -> a later Get returns 64'h0123_4567_FFFF_FFFF.
- **Denials**:
  - Get at BASE_ADDR+DEPTH*8 -> AccessAckData, denied 1, corrupt 1, data 0.
  - Put with size 2 at an address with bit 1 set -> AccessAck, denied 1, memory unchanged.
  - Opcode 2 -> AccessAck, denied 1.
- **Backpressure**: d_ready=0 for 5 cycles with a_valid held -> a_ready=0 and d_bits stable throughout; raising d_ready yields a_fire in that same cycle.
- **Streaming**: 16 back-to-back Gets with d_ready=1 -> 16 responses on consecutive cycles with sources in order and no bubbles.
